// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel column/row and the visible-area flag from
// active-low hSync/vSync sampled on the system clock. It also checks line and
// frame periods against the programmed timing and reports lock status.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   hSync/vSync  active-low syncs, synchronous to clk
//   rx_x/rx_y    recovered column/row (0 at the matching sync falling edge)
//   rx_active    locked and (rx_x, rx_y) inside the visible window
//   locked       timing lock established
//   frame_start  pulse on every vSync fall seen while acquiring or locked
//   line_err     pulse on a failed line-period check or a line timeout
//   frame_err    pulse on a failed frame-period check
//   err_count    number of lock losses, saturating at 255
module vga_sync_receiver #(
  parameter int unsigned CLKS_PER_PIXEL = 4,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned H_ACT_START    = 144,
  parameter int unsigned H_ACT          = 640,
  parameter int unsigned V_ACT_START    = 35,
  parameter int unsigned V_ACT          = 480,
  parameter int unsigned LOCK_FRAMES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       rx_active,
  output logic       locked,
  output logic       frame_start,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int unsigned LINE_CLKS = H_TOTAL * CLKS_PER_PIXEL;
  localparam int unsigned PW        = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int unsigned GW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0] LC_MAX    = 12'hFFF;
  localparam logic [9:0]  POS_MAX   = 10'h3FF;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  logic          r_hs_prev, r_vs_prev;
  logic [11:0]   r_line_clk;
  logic [PW-1:0] r_pix_div;
  logic [9:0]    r_rx_x, r_rx_y;

  state_t        r_state, w_state_n;
  logic [GW-1:0] r_good, w_good_n, w_good_inc;
  logic          r_skip, w_skip_n;
  logic          r_line_seen_err, w_line_seen_err_n;
  logic [7:0]    r_err_count, w_err_count_n;
  logic          r_locked, r_frame_start, r_line_err, r_frame_err;
  logic          w_frame_start_c, w_line_err_c, w_frame_err_c;

  logic          w_hfall, w_vfall, w_line_fail, w_frame_fail, w_timeout;
  logic          w_in_h, w_in_v;

  assign w_hfall      = r_hs_prev & ~hSync;
  assign w_vfall      = r_vs_prev & ~vSync;
  assign w_line_fail  = w_hfall & (r_line_clk != 12'(LINE_CLKS - 1));
  assign w_frame_fail = w_vfall & (r_rx_y != 10'(V_TOTAL - 1));
  assign w_timeout    = (r_line_clk == LC_MAX);
  assign w_good_inc   = r_good + GW'(1);

  // Sync edge history and position recovery
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_prev  <= 1'b1;
      r_vs_prev  <= 1'b1;
      r_line_clk <= '0;
      r_pix_div  <= '0;
      r_rx_x     <= '0;
      r_rx_y     <= '0;
    end else begin
      r_hs_prev <= hSync;
      r_vs_prev <= vSync;
      if (w_hfall) begin
        r_line_clk <= '0;
        r_pix_div  <= '0;
        r_rx_x     <= '0;
      end else begin
        if (r_line_clk != LC_MAX) r_line_clk <= r_line_clk + 12'd1;
        if (r_pix_div == PW'(CLKS_PER_PIXEL - 1)) begin
          r_pix_div <= '0;
          if (r_rx_x != POS_MAX) r_rx_x <= r_rx_x + 10'd1;
        end else begin
          r_pix_div <= r_pix_div + PW'(1);
        end
      end
      // vfall normally coincides with hfall and must win
      if (w_vfall) r_rx_y <= '0;
      else if (w_hfall && (r_rx_y != POS_MAX)) r_rx_y <= r_rx_y + 10'd1;
    end
  end

  // Lock state register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_UNLOCKED;
      r_good          <= '0;
      r_skip          <= 1'b0;
      r_line_seen_err <= 1'b0;
      r_err_count     <= '0;
      r_locked        <= 1'b0;
      r_frame_start   <= 1'b0;
      r_line_err      <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_good          <= w_good_n;
      r_skip          <= w_skip_n;
      r_line_seen_err <= w_line_seen_err_n;
      r_err_count     <= w_err_count_n;
      r_locked        <= (w_state_n == ST_LOCKED);
      r_frame_start   <= w_frame_start_c;
      r_line_err      <= w_line_err_c;
      r_frame_err     <= w_frame_err_c;
    end
  end

  // Lock next-state and pulse decode
  always_comb begin
    w_state_n         = r_state;
    w_good_n          = r_good;
    w_skip_n          = r_skip;
    w_line_seen_err_n = r_line_seen_err;
    w_err_count_n     = r_err_count;
    w_frame_start_c   = 1'b0;
    w_line_err_c      = 1'b0;
    w_frame_err_c     = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_vfall) begin
          w_state_n         = ST_ACQUIRE;
          w_good_n          = '0;
          w_skip_n          = 1'b1;
          w_line_seen_err_n = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        w_frame_start_c = w_vfall;
        // The first line after acquisition starts may be partial
        w_line_err_c    = (w_line_fail & ~r_skip) | w_timeout;
        w_frame_err_c   = w_frame_fail;
        if (w_hfall) w_skip_n = 1'b0;
        if (w_timeout) begin
          w_state_n = ST_UNLOCKED;
          w_good_n  = '0;
        end else if (w_vfall) begin
          w_line_seen_err_n = 1'b0;
          if (w_frame_fail || w_line_err_c || r_line_seen_err) begin
            w_good_n = '0;
          end else begin
            w_good_n = w_good_inc;
            if (w_good_inc == GW'(LOCK_FRAMES)) w_state_n = ST_LOCKED;
          end
        end else if (w_line_err_c) begin
          w_good_n          = '0;
          w_line_seen_err_n = 1'b1;
        end
      end
      ST_LOCKED: begin
        w_frame_start_c = w_vfall;
        w_line_err_c    = w_line_fail | w_timeout;
        w_frame_err_c   = w_frame_fail;
        if (w_line_err_c || w_frame_err_c) begin
          w_state_n = ST_UNLOCKED;
          if (r_err_count != 8'hFF) w_err_count_n = r_err_count + 8'd1;
        end
      end
      default: w_state_n = ST_UNLOCKED;
    endcase
  end

  assign w_in_h = (r_rx_x >= 10'(H_ACT_START)) && (r_rx_x < 10'(H_ACT_START + H_ACT));
  assign w_in_v = (r_rx_y >= 10'(V_ACT_START)) && (r_rx_y < 10'(V_ACT_START + V_ACT));

  assign rx_x        = r_rx_x;
  assign rx_y        = r_rx_y;
  assign rx_active   = r_locked & w_in_h & w_in_v;
  assign locked      = r_locked;
  assign frame_start = r_frame_start;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a small raster so that full
// frames and hundreds of relock cycles stay short.
module tb_vga_sync_receiver;

  localparam int CPP  = 2;
  localparam int HT   = 6;
  localparam int VT   = 5;
  localparam int HAS  = 3;
  localparam int HA   = 2;
  localparam int VAS  = 2;
  localparam int VA   = 2;
  localparam int LF   = 2;
  localparam int HS_W = 2;
  localparam int VS_W = 1;
  localparam int STRETCH = 4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       hSync, vSync;
  logic [9:0] rx_x, rx_y;
  logic       rx_active, locked, frame_start, line_err, frame_err;
  logic [7:0] err_count;

  exp_t sb[$];

  int n_checks, n_errors;
  int n_le, n_fe, n_fs, n_loss, vf_count;
  int rise_vf, loss_vf;
  bit rise_on_vf, loss_on_hf, loss_on_vf;
  bit prev_locked, prev_hs, prev_vs;
  bit seen_active;
  int first_x, first_y;

  vga_sync_receiver #(
    .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACT_START(HAS), .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .hSync(hSync), .vSync(vSync),
    .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active), .locked(locked),
    .frame_start(frame_start), .line_err(line_err), .frame_err(frame_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the reference raster at pixel (h, v); outputs sampled at the
  // following negedge reflect exactly these inputs.
  task automatic step(input int h, input int v, input bit chk_pos, input bit do_rst);
    exp_t e;
    bit hs, vs, hf, vf;
    hs = (h >= HS_W);
    vs = (v >= VS_W);
    hf = prev_hs & ~hs & ~do_rst;
    vf = prev_vs & ~vs & ~do_rst;
    rst   = do_rst;
    hSync = hs;
    vSync = vs;
    if (chk_pos) begin
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.act = (h >= HAS) && (h < HAS + HA) && (v >= VAS) && (v < VAS + VA);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (vf) vf_count++;
    if (do_rst) begin
      check("rst_rx_x", rx_x, 0);
      check("rst_rx_y", rx_y, 0);
      check("rst_locked", locked, 0);
      check("rst_rx_active", rx_active, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_line_err", line_err, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_count", err_count, 0);
    end
    if (chk_pos) begin
      e = sb.pop_front();
      check("pos_rx_x", rx_x, e.x);
      check("pos_rx_y", rx_y, e.y);
      check("pos_rx_active", rx_active, e.act);
      if (rx_active && !seen_active) begin
        seen_active = 1'b1;
        first_x = int'(rx_x);
        first_y = int'(rx_y);
      end
    end
    if (line_err)    n_le++;
    if (frame_err)   n_fe++;
    if (frame_start) n_fs++;
    if (!prev_locked && locked) begin
      rise_vf    = vf_count;
      rise_on_vf = vf;
    end
    if (prev_locked && !locked) begin
      n_loss++;
      loss_vf    = vf_count;
      loss_on_hf = hf;
      loss_on_vf = vf;
    end
    prev_locked = locked;
    prev_hs = hs;
    prev_vs = vs;
    rst = 1'b0;
  endtask

  // One frame of 'lines' lines; optional stretched line and reset point.
  task automatic gen_frame(input int lines, input int stretch_row, input int rst_row,
                           input bit chk_pos);
    for (int v = 0; v < lines; v++)
      for (int h = 0; h < HT; h++)
        for (int d = 0; d < CPP + (((h == HT - 1) && (v == stretch_row)) ? STRETCH : 0); d++)
          step(h, v, chk_pos, (v == rst_row) && (h == 3) && (d == 0));
  endtask

  initial begin
    int le0, fe0, fs0, loss0, stall_loss_vf, rst_loss_vf;
    n_checks = 0; n_errors = 0;
    n_le = 0; n_fe = 0; n_fs = 0; n_loss = 0; vf_count = 0;
    rise_vf = -1; loss_vf = -1; rise_on_vf = 0; loss_on_hf = 0; loss_on_vf = 0;
    prev_locked = 0; prev_hs = 1; prev_vs = 1; seen_active = 0;
    first_x = -1; first_y = -1;
    rst = 1'b1; hSync = 1'b1; vSync = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("reset_rx_x", rx_x, 0);
    check("reset_rx_y", rx_y, 0);
    check("reset_locked", locked, 0);
    check("reset_rx_active", rx_active, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_line_err", line_err, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_err_count", err_count, 0);
    rst = 1'b0;

    // Nominal acquisition, then a fully compared locked frame
    gen_frame(VT, -1, -1, 0);
    gen_frame(VT, -1, -1, 0);
    check("locked_before_3rd_vfall", locked, 0);
    gen_frame(VT, -1, -1, 1);
    check("lock_vfall_index", rise_vf, 3);
    check("lock_on_vfall_step", rise_on_vf, 1);
    check("acq_frame_start_pulses", n_fs, 2);
    check("acq_line_err", n_le, 0);
    check("acq_frame_err", n_fe, 0);
    check("acq_err_count", err_count, 0);
    check("first_active_x", first_x, HAS);
    check("first_active_y", first_y, VAS);

    // Stretched line while locked
    le0 = n_le; fe0 = n_fe;
    gen_frame(VT, 1, -1, 0);
    check("stretch_line_err", n_le - le0, 1);
    check("stretch_frame_err", n_fe - fe0, 0);
    check("stretch_unlock_on_hfall", loss_on_hf, 1);
    check("stretch_err_count", err_count, 1);
    check("stretch_locked", locked, 0);
    repeat (3) gen_frame(VT, -1, -1, 0);
    check("stretch_relock_vfalls", rise_vf - loss_vf, 3);
    check("stretch_relocked", locked, 1);

    // Short frame while locked
    le0 = n_le; fe0 = n_fe;
    gen_frame(VT - 1, -1, -1, 0);
    gen_frame(VT, -1, -1, 0);
    check("short_frame_err", n_fe - fe0, 1);
    check("short_line_err", n_le - le0, 0);
    check("short_unlock_on_vfall", loss_on_vf, 1);
    check("short_err_count", err_count, 2);
    gen_frame(VT, -1, -1, 0);
    gen_frame(VT, -1, -1, 0);
    gen_frame(VT, -1, -1, 1);
    check("short_relock_vfalls", rise_vf - loss_vf, 3);

    // hSync stuck high while locked
    le0 = n_le; fe0 = n_fe; fs0 = n_fs; loss0 = n_loss;
    repeat (4200) step(HT - 1, VT - 1, 0, 0);
    check("timeout_line_err", n_le - le0, 1);
    check("timeout_frame_err", n_fe - fe0, 0);
    check("timeout_frame_start", n_fs - fs0, 0);
    check("timeout_locked", locked, 0);
    check("timeout_loss", n_loss - loss0, 1);
    check("timeout_err_count", err_count, 3);
    stall_loss_vf = loss_vf;
    gen_frame(VT, -1, -1, 0);
    check("resume_no_frame_start", n_fs - fs0, 0);
    gen_frame(VT, -1, -1, 0);

    // Locked, then reset in the middle of the frame
    gen_frame(VT, -1, 2, 0);
    check("timeout_relock_vfalls", rise_vf - stall_loss_vf, 3);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_locked", locked, 0);
    rst_loss_vf = loss_vf;
    gen_frame(VT, -1, -1, 0);
    gen_frame(VT, -1, -1, 0);

    // 256 forced lock losses via two-line frames
    le0 = n_le; fe0 = n_fe; loss0 = n_loss;
    for (int i = 0; i < 256; i++) begin
      gen_frame(2, -1, -1, 0);
      if (i == 0) check("rst_relock_vfalls", rise_vf - rst_loss_vf, 3);
      gen_frame(2, -1, -1, 0);
      gen_frame(VT, -1, -1, 0);
      gen_frame(VT, -1, -1, 0);
      if (i == 254) check("err_count_at_255_losses", err_count, 255);
    end
    check("err_count_saturated", err_count, 255);
    check("forced_losses", n_loss - loss0, 256);
    check("forced_frame_errs", n_fe - fe0, 256);
    check("forced_line_errs", n_le - le0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
